// File: rtl/hazard_control_unit_pkg.sv
// rtl/hazard_control_unit_pkg.sv - shared state encodings, limits and control bundle for the hazard controller
package hazard_control_unit_pkg;

    localparam int HZ_CNT_W  = 4;
    localparam int HZ_LU_MAX = 15;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LU_HOLD  = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } hzState_t;

    typedef struct packed {
        logic pcWrite;
        logic ifIdWrite;
        logic idExBubble;
        logic flushIfId;
        logic flushIdEx;
        logic freeze;
    } hzCtrl_t;

endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - one ID-stage source compared against the EX destination
module hazard_src_match #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              used,
    input  logic [REG_AW-1:0] rd,
    output logic              match
);

    assign match = used & (rs == rd);

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use / mem-busy / redirect hazard controller for the 5-stage pipe
// Optional performance counters enabled by defining HAZARD_PERF_EN.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_AW          = 5,
    parameter int NUM_RS          = 2,
    parameter int LOAD_USE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RS*REG_AW-1:0] id_rs,
    input  logic [NUM_RS-1:0]        id_rs_used,
    input  logic                     id_valid,
    input  logic [REG_AW-1:0]        ex_rd,
    input  logic                     ex_mem_read,
    input  logic                     ex_valid,
    input  logic                     ex_branch_taken,
    input  logic                     mem_busy,
    output logic                     pc_write,
    output logic                     if_id_write,
    output logic                     id_ex_bubble,
    output logic                     flush_if_id,
    output logic                     flush_id_ex,
    output logic                     freeze,
    output logic [31:0]              perf_stall_cnt,
    output logic [31:0]              perf_flush_cnt
);

    localparam logic [HZ_CNT_W-1:0] CNT_INIT = HZ_CNT_W'(LOAD_USE_CYCLES - 1);
    localparam logic [HZ_CNT_W-1:0] CNT_ONE  = HZ_CNT_W'(1);

    hzState_t            state;
    logic [HZ_CNT_W-1:0] cnt;
    logic                luSaved;
    logic [NUM_RS-1:0]   matchVec;
    logic                hit;
    logic                inHold;
    hzCtrl_t             ctrl;

    for (genvar i = 0; i < NUM_RS; i++) begin : gSrc
        hazard_src_match #(.REG_AW(REG_AW)) uMatch (
            .rs    (id_rs[i*REG_AW +: REG_AW]),
            .used  (id_rs_used[i]),
            .rd    (ex_rd),
            .match (matchVec[i])
        );
    end

    assign hit = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) & (|matchVec);

    // After a memory freeze the saved bit stands in for the state we left, so a stall resumes at once.
    assign inHold = (state == HZ_LU_HOLD) || ((state == HZ_MEM_WAIT) && luSaved);

    always_comb begin
        ctrl = '{pcWrite: 1'b1, ifIdWrite: 1'b1, default: 1'b0};
        if (rst) begin
            ctrl = '{pcWrite: 1'b1, ifIdWrite: 1'b1, default: 1'b0};
        end else if (mem_busy) begin
            ctrl = '{freeze: 1'b1, default: 1'b0};
        end else if (ex_branch_taken) begin
            ctrl = '{pcWrite: 1'b1, ifIdWrite: 1'b1, flushIfId: 1'b1, flushIdEx: 1'b1, default: 1'b0};
        end else if (inHold || hit) begin
            ctrl = '{idExBubble: 1'b1, default: 1'b0};
        end
    end

    assign pc_write     = ctrl.pcWrite;
    assign if_id_write  = ctrl.ifIdWrite;
    assign id_ex_bubble = ctrl.idExBubble;
    assign flush_if_id  = ctrl.flushIfId;
    assign flush_id_ex  = ctrl.flushIdEx;
    assign freeze       = ctrl.freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HZ_RUN;
            cnt     <= '0;
            luSaved <= 1'b0;
        end else if (mem_busy) begin
            state <= HZ_MEM_WAIT;
            if (state != HZ_MEM_WAIT) begin
                luSaved <= (state == HZ_LU_HOLD);
            end
        end else if (ex_branch_taken) begin
            state   <= HZ_RUN;
            cnt     <= '0;
            luSaved <= 1'b0;
        end else if (inHold) begin
            luSaved <= 1'b0;
            if (cnt <= CNT_ONE) begin
                state <= HZ_RUN;
                cnt   <= '0;
            end else begin
                state <= HZ_LU_HOLD;
                cnt   <= cnt - CNT_ONE;
            end
        end else if (hit && (LOAD_USE_CYCLES > 1)) begin
            state   <= HZ_LU_HOLD;
            cnt     <= CNT_INIT;
            luSaved <= 1'b0;
        end else begin
            state   <= HZ_RUN;
            luSaved <= 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (ctrl.idExBubble && (stallCnt != 32'hFFFF_FFFF)) begin
                stallCnt <= stallCnt + 32'd1;
            end
            if (ctrl.flushIdEx && (flushCnt != 32'hFFFF_FFFF)) begin
                flushCnt <= flushCnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stallCnt;
    assign perf_flush_cnt = flushCnt;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed checks of the hazard controller at LOAD_USE_CYCLES 1 and 3
module tb_hazard_control_unit;

    localparam logic [5:0] RUNO  = 6'b110000;
    localparam logic [5:0] STALL = 6'b001000;
    localparam logic [5:0] FLUSH = 6'b110110;
    localparam logic [5:0] FRZ   = 6'b000001;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic        id_valid;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_valid;
    logic        ex_branch_taken;
    logic        mem_busy;

    logic        pcW1, ifW1, bub1, fIf1, fEx1, frz1;
    logic        pcW3, ifW3, bub3, fIf3, fEx3, frz3;
    logic [31:0] pS1, pF1, pS3, pF3;

    int compCnt = 0;
    int errCnt  = 0;
    int mS1 = 0, mF1 = 0, mS3 = 0, mF3 = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.REG_AW(5), .NUM_RS(2), .LOAD_USE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used), .id_valid(id_valid),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_valid(ex_valid),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(pcW1), .if_id_write(ifW1), .id_ex_bubble(bub1), .flush_if_id(fIf1),
        .flush_id_ex(fEx1), .freeze(frz1), .perf_stall_cnt(pS1), .perf_flush_cnt(pF1)
    );

    hazard_control_unit #(.REG_AW(5), .NUM_RS(2), .LOAD_USE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used), .id_valid(id_valid),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_valid(ex_valid),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(pcW3), .if_id_write(ifW3), .id_ex_bubble(bub3), .flush_if_id(fIf3),
        .flush_id_ex(fEx3), .freeze(frz3), .perf_stall_cnt(pS3), .perf_flush_cnt(pF3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [5:0] e1, input logic [5:0] e3);
        @(negedge clk);
        check({tag, "/L1"}, {26'd0, pcW1, ifW1, bub1, fIf1, fEx1, frz1}, {26'd0, e1});
        check({tag, "/L3"}, {26'd0, pcW3, ifW3, bub3, fIf3, fEx3, frz3}, {26'd0, e3});
        if (rst) begin
            mS1 = 0; mF1 = 0; mS3 = 0; mF3 = 0;
        end else begin
            mS1 += int'(e1[3]); mF1 += int'(e1[1]);
            mS3 += int'(e3[3]); mF3 += int'(e3[1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkPerf(input string tag);
        check({tag, "/stall1"}, pS1, PERF ? 32'(mS1) : 32'd0);
        check({tag, "/flush1"}, pF1, PERF ? 32'(mF1) : 32'd0);
        check({tag, "/stall3"}, pS3, PERF ? 32'(mS3) : 32'd0);
        check({tag, "/flush3"}, pF3, PERF ? 32'(mF3) : 32'd0);
    endtask

    task automatic idle();
        id_rs = '0; id_rs_used = '0; id_valid = 1'b1; ex_rd = '0; ex_mem_read = 1'b0;
        ex_valid = 1'b1; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic loadHit(input int src, input logic [4:0] r);
        id_rs = '0; id_rs_used = '0;
        id_rs[src*5 +: 5] = r; id_rs_used[src] = 1'b1;
        ex_rd = r; ex_mem_read = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        loadHit(0, 5'd5);
        step("reset_forced", RUNO, RUNO);
        checkPerf("perf_after_reset");

        // lw x5 in EX, rs1=x5: one bubble at L1, three at L3
        rst = 1'b0;
        step("lu1_hit", STALL, STALL);
        idle();
        step("lu1_after1", RUNO, STALL);
        step("lu1_after2", RUNO, STALL);
        step("lu1_done", RUNO, RUNO);

        // rs2=x7 hit held four cycles: L3 finishes one hazard and starts a fresh one
        loadHit(1, 5'd7);
        step("rs2_c1", STALL, STALL);
        step("rs2_c2", STALL, STALL);
        step("rs2_c3", STALL, STALL);
        step("rs2_fresh", STALL, STALL);
        idle();
        step("rs2_tail1", RUNO, STALL);
        step("rs2_tail2", RUNO, STALL);
        step("rs2_run", RUNO, RUNO);

        // cases that must never stall
        idle(); loadHit(0, 5'd0);
        step("x0_load", RUNO, RUNO);
        loadHit(0, 5'd9); id_rs_used = 2'b00;
        step("unused_src", RUNO, RUNO);
        loadHit(0, 5'd9); ex_valid = 1'b0;
        step("ex_invalid", RUNO, RUNO);
        loadHit(1, 5'd9); id_valid = 1'b0;
        step("id_invalid", RUNO, RUNO);
        idle(); loadHit(0, 5'd9); ex_mem_read = 1'b0;
        step("not_load", RUNO, RUNO);

        // hit with redirect in the same cycle: flush wins, no stall left behind
        idle(); loadHit(0, 5'd3); ex_branch_taken = 1'b1;
        step("hit_branch", FLUSH, FLUSH);
        idle();
        step("after_branch", RUNO, RUNO);

        // freeze four cycles in the middle of an L3 hold
        loadHit(1, 5'd12);
        step("frz_hit", STALL, STALL);
        idle(); mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) step("frz_busy", FRZ, FRZ);
        mem_busy = 1'b0;
        step("frz_resume1", RUNO, STALL);
        step("frz_resume2", RUNO, STALL);
        step("frz_run", RUNO, RUNO);

        // mem_busy outranks redirect and hazard
        loadHit(0, 5'd4); ex_branch_taken = 1'b1; mem_busy = 1'b1;
        step("busy_prio", FRZ, FRZ);
        mem_busy = 1'b0;
        step("branch_after_busy", FLUSH, FLUSH);

        // reset in the middle of a stall
        idle(); loadHit(0, 5'd6);
        step("rst_mid_hit", STALL, STALL);
        idle();
        checkPerf("perf_before_reset");
        rst = 1'b1;
        step("rst_mid_forced", RUNO, RUNO);
        rst = 1'b0;
        step("rst_mid_release", RUNO, RUNO);
        checkPerf("perf_cleared");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, errCnt);
        $finish;
    end

endmodule
